keypad_scanner: RTL
===================

# keypad_scanner

Sequencer for the 4x4 matrix keypad front-end. It drives the keypad rows one-hot in rotation and samples the column lines through a 2-FF synchronizer. It debounces a press, maps the (row, column) position to the team's 4-bit key code, and emits a one-cycle `key_valid` strobe per press. The calculator datapath consumes `key_code`/`key_valid`; the raw matrix lines go only to this block.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clocks per scan tick. Legal range ≥ 4; smaller values are illegal.
- `DB_TICKS`, default 20: number of consecutive stable ticks required to accept a press or a release. Legal range ≥ 1.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `col_in`, in, 4: raw column lines, asynchronous, active-high. `col_in[0]` = col1 … `col_in[3]` = col4.
- `row_drv`, out, 4: one-hot row drive, registered. `row_drv[0]` = row1 … `row_drv[3]` = row4.
- `key_code`, out, 4: code of the last accepted key. Held until the next accepted key.
- `key_valid`, out, 1: one-clock strobe; `key_code` is valid in the same cycle.
- `key_down`, out, 1: high while the FSM is in DEBOUNCE or HOLD.

## Operation
- Synchronizer: `col_in` passes through 2 flops to give `col_s`. All decisions use `col_s`.
- Prescaler: counts 0..SCAN_DIV-1. `tick` is asserted in the cycle where the count equals SCAN_DIV-1; the counter then wraps to 0. All FSM actions below happen only on `tick`.
- Key map, keyed by (row, col):
  - row1: 1, 2, 3, A(10, plus)
  - row2: 4, 5, 6, B(11, minus)
  - row3: 7, 8, 9, C(12, equals)
  - row4: col2 = 0. Row4 col1, col3 and col4 are unmapped.
- FSM states: SCAN, DEBOUNCE, HOLD.
  - SCAN, `col_s` == 0: rotate `row_drv` left (0001→0010→0100→1000→0001).
  - SCAN, `col_s` != 0: capture `cap_col` = `col_s`, freeze `row_drv`, clear `db_cnt`, go to DEBOUNCE.
  - DEBOUNCE, `col_s` == `cap_col`: increment `db_cnt`.
    - When `db_cnt` reaches DB_TICKS-1 and the key is accepted, load `key_code` and pulse `key_valid`, then go to HOLD.
    - Acceptance requires `cap_col` to be one-hot and the position to be mapped. Otherwise there is no pulse, but the FSM still goes to HOLD.
  - DEBOUNCE, `col_s` != `cap_col` (bounce, change, or release): return to SCAN. `row_drv` is unchanged on that tick and scanning resumes from the same row.
  - HOLD, `col_s` == 0: increment `rel_cnt`. On reaching DB_TICKS-1, go to SCAN and clear `rel_cnt`.
  - HOLD, `col_s` != 0: clear `rel_cnt`.
- Multiple keys pressed:
  - Several columns in the frozen row: not one-hot, so no event. The FSM waits in HOLD for a full release.
  - Keys in other rows are invisible while the row is frozen. No rollover: exactly one event per press-release cycle.
- Counter widths: `db_cnt` and `rel_cnt` are $clog2(DB_TICKS+1) bits; the prescaler is $clog2(SCAN_DIV) bits. No counter ever wraps.

## Timing
- Reset values: `row_drv`=0001, `key_code`=0, `key_valid`=0, `key_down`=0, state SCAN, all counters 0, synchronizer flops 0.
- First tick after reset is in cycle SCAN_DIV-1, counting the first cycle after `rst` deasserts as cycle 0.
- `row_drv` changes in the clock after a tick. A row is therefore driven for SCAN_DIV clocks, and sampling happens at least SCAN_DIV-3 clocks after the column lines settle.
- Press latency:
  - Column transition to synchronizer output: 2 clocks.
  - Synchronizer output to the first SCAN tick that sees it, which enters DEBOUNCE: up to 4·SCAN_DIV clocks.
  - DEBOUNCE to strobe: DB_TICKS ticks. `key_valid` and the new `key_code` are registered and appear in the clock after the accepting tick.
- `key_valid` is high for exactly 1 clock. `key_down` is registered from the state.
- Reset mid-operation, in any state: all outputs return to their reset values on the next clock. A pending `key_valid` is suppressed. A key still held after reset is re-detected and re-debounced as a new press.
- `rst` has priority over `tick`.

## Test plan
All scenarios use SCAN_DIV=4 and DB_TICKS=3.
- Press row2/col2 (drive `col_in`=0010 only while `row_drv`=0010), hold for 40 clocks, then release for 40 clocks → exactly one `key_valid`, `key_code`=5, and `key_down` falls only after 3 clean release ticks.
- Bounce: row1/col4 toggles each tick for 2 ticks, then holds stable → no strobe during the bounce, then one strobe with `key_code`=10 (0xA).
- Two keys in row3 (`col_in`=0011) → `key_down`=1 and no `key_valid`. After release and a new press of row3/col3 → one strobe with `key_code`=9.
- Unmapped key row4/col4 held → no strobe, `key_code` keeps its previous value. Row4/col2 → `key_code`=0 with a strobe.
- Hold row1/col1 for 200 clocks → a single strobe (`key_code`=1), with no repeats during the hold.
- Assert `rst` for 1 clock while in HOLD → `row_drv`=0001 and `key_down`=0 next clock. The key still held is re-detected as a new press, giving one new strobe after debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad sequencer.
// Drives the keypad rows one-hot in rotation and samples the column lines
// through a two-flop synchronizer. A press is debounced, mapped to a 4-bit
// key code and reported with a single key_valid strobe.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   col_in    in   [3:0] raw asynchronous column lines, active-high
//   row_drv   out  [3:0] registered one-hot row drive
//   key_code  out  [3:0] code of the last accepted key, held until the next one
//   key_valid out  one-clock strobe, key_code valid in the same cycle
//   key_down  out  high while a key is being debounced or held
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DB_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_drv,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DB_TICKS + 1);
  localparam logic [PW-1:0] DIV_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    col_s_q, col_s_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    cap_col_q, cap_col_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;

  logic          tick;
  logic          map_ok;
  logic [3:0]    map_code;

  // Key map on the frozen row and the captured columns. Only one-hot column
  // patterns are listed, so multi-column presses fall through as unmapped.
  always_comb begin
    map_ok   = 1'b1;
    map_code = '0;
    case ({row_q, cap_col_q})
      8'b0001_0001: map_code = 4'd1;
      8'b0001_0010: map_code = 4'd2;
      8'b0001_0100: map_code = 4'd3;
      8'b0001_1000: map_code = 4'd10;
      8'b0010_0001: map_code = 4'd4;
      8'b0010_0010: map_code = 4'd5;
      8'b0010_0100: map_code = 4'd6;
      8'b0010_1000: map_code = 4'd11;
      8'b0100_0001: map_code = 4'd7;
      8'b0100_0010: map_code = 4'd8;
      8'b0100_0100: map_code = 4'd9;
      8'b0100_1000: map_code = 4'd12;
      8'b1000_0010: map_code = 4'd0;
      default:      map_ok   = 1'b0;
    endcase
  end

  always_comb begin
    sync1_d     = col_in;
    col_s_d     = sync1_q;
    state_d     = state_q;
    row_d       = row_q;
    cap_col_d   = cap_col_q;
    db_cnt_d    = db_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    tick  = (pre_q == DIV_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);

    if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (col_s_q == '0) begin
            row_d = {row_q[2:0], row_q[3]};
          end else begin
            cap_col_d = col_s_q;
            db_cnt_d  = '0;
            state_d   = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (col_s_q == cap_col_q) begin
            if (db_cnt_q == CNT_LAST) begin
              // Unmapped or multi-column presses still park in HOLD so
              // that exactly one release is needed before rescanning.
              state_d = S_HOLD;
              if (map_ok) begin
                key_code_d  = map_code;
                key_valid_d = 1'b1;
              end
            end else begin
              db_cnt_d = db_cnt_q + CW'(1);
            end
          end else begin
            state_d = S_SCAN;
          end
        end
        S_HOLD: begin
          if (col_s_q == '0) begin
            if (rel_cnt_q == CNT_LAST) begin
              rel_cnt_d = '0;
              state_d   = S_SCAN;
            end else begin
              rel_cnt_d = rel_cnt_q + CW'(1);
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: state_d = S_SCAN;
      endcase
    end

    key_down_d = (state_d != S_SCAN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SCAN;
      sync1_q     <= '0;
      col_s_q     <= '0;
      pre_q       <= '0;
      row_q       <= 4'b0001;
      cap_col_q   <= '0;
      db_cnt_q    <= '0;
      rel_cnt_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      col_s_q     <= col_s_d;
      pre_q       <= pre_d;
      row_q       <= row_d;
      cap_col_q   <= cap_col_d;
      db_cnt_q    <= db_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign row_drv   = row_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
